// File: rtl/proc_trace_buffer_pkg.sv
// Shared definitions for the processor trace buffer: FSM states, halt-cause codes
// and the trace-entry record layout (shown at the default widths) with its width helper.
package proc_trace_pkg;

  typedef enum logic [1:0] {
    HALT_NONE  = 2'd0,
    HALT_LIMIT = 2'd1,
    HALT_STALL = 2'd2
  } halt_cause_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_REG_W  = 5;
  localparam int DEF_CYC_W  = 16;

  // Field order is the storage order inside the FIFO, MSB first.
  typedef struct packed {
    logic [DEF_CYC_W-1:0]  cycle;
    logic                  rf_valid;
    logic [DEF_REG_W-1:0]  rf_reg;
    logic [DEF_DATA_W-1:0] rf_data;
    logic                  mem_valid;
    logic [DEF_ADDR_W-1:0] mem_addr;
    logic [DEF_DATA_W-1:0] mem_data;
  } trace_entry_t;

  function automatic int entry_width(input int cyc_w, input int reg_w,
                                     input int data_w, input int addr_w);
    return cyc_w + 1 + reg_w + data_w + 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/proc_trace_buffer_if.sv
// Tap and drain bundle for proc_trace_buffer: processor writeback/store taps in,
// show-ahead valid/ready read port out.
interface proc_trace_buffer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int REG_W  = 5,
  parameter int CYC_W  = 16
);

  logic [31:0]       pc;
  logic              rf_we;
  logic [REG_W-1:0]  rf_reg;
  logic [DATA_W-1:0] rf_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  logic              rd_ready;
  logic              rd_valid;
  logic [CYC_W-1:0]  rd_cycle;
  logic              rd_rf_valid;
  logic [REG_W-1:0]  rd_rf_reg;
  logic [DATA_W-1:0] rd_rf_data;
  logic              rd_mem_valid;
  logic [ADDR_W-1:0] rd_mem_addr;
  logic [DATA_W-1:0] rd_mem_data;

  modport master (
    output pc, rf_we, rf_reg, rf_data, mem_we, mem_addr, mem_data, rd_ready,
    input  rd_valid, rd_cycle, rd_rf_valid, rd_rf_reg, rd_rf_data,
           rd_mem_valid, rd_mem_addr, rd_mem_data
  );

  modport slave (
    input  pc, rf_we, rf_reg, rf_data, mem_we, mem_addr, mem_data, rd_ready,
    output rd_valid, rd_cycle, rd_rf_valid, rd_rf_reg, rd_rf_data,
           rd_mem_valid, rd_mem_addr, rd_mem_data
  );

endinterface

// File: rtl/proc_trace_buffer_fifo.sv
// trace_fifo: show-ahead synchronous FIFO with extra-MSB pointers; optional overwrite
// mode discards the oldest entry when a push meets a full FIFO with no pop.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic             overwrite,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;
  logic             discard;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign discard = push && full && !do_pop && overwrite;
  assign do_push = push && (!full || do_pop || overwrite);

  // Zero when empty so the read fields are quiet in reset and between entries.
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop || discard) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/proc_trace_buffer.sv
// proc_trace_buffer: cycle-stamped capture of regfile writebacks and dmem stores.
// Build option PROC_TRACE_WRAP_EN: keep newest entries (discard oldest) on overflow.
module proc_trace_buffer
  import proc_trace_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int REG_W       = 5,
  parameter int DEPTH       = 16,
  parameter int CYC_W       = 16,
  parameter int CYCLE_LIMIT = 50,
  parameter int HALT_REPEAT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  proc_trace_buffer_if.slave   bus,
  output logic                 running,
  output logic                 done,
  output logic [1:0]           halt_cause,
  output logic                 overflow,
  output logic [CYC_W-1:0]     drop_count
);

  localparam int ENTRY_W = entry_width(CYC_W, REG_W, DATA_W, ADDR_W);
  localparam int STALL_W = $clog2(HALT_REPEAT) + 1;

  typedef struct packed {
    logic [CYC_W-1:0]  cycle;
    logic              rf_valid;
    logic [REG_W-1:0]  rf_reg;
    logic [DATA_W-1:0] rf_data;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
  } entry_t;

  state_t            state_q, state_d;
  halt_cause_t       cause_q, cause_d;
  logic [CYC_W-1:0]  cyc_q;
  logic [STALL_W-1:0] stall_q;
  logic [31:0]       prev_pc_q;
  logic              overflow_q;
  logic [CYC_W-1:0]  drop_q;

  logic              in_run;
  logic              pc_same;
  logic              limit_at;
  logic              stall_at;
  logic              rf_hit;
  logic              capture;
  logic              pop_fire;
  logic              lost;
  logic              overwrite;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ENTRY_W-1:0] fifo_rdata;
  entry_t            push_entry;
  entry_t            head;

`ifdef PROC_TRACE_WRAP_EN
  assign overwrite = 1'b1;
`else
  assign overwrite = 1'b0;
`endif

  assign in_run   = (state_q == S_RUN);
  assign pc_same  = (bus.pc == prev_pc_q);
  assign limit_at = (cyc_q == CYC_W'(CYCLE_LIMIT - 1));
  // stall_q counts repeats; HALT_REPEAT cycles at one PC means HALT_REPEAT-1 repeats.
  assign stall_at = in_run && pc_same && (stall_q >= STALL_W'(HALT_REPEAT - 2));
  assign rf_hit   = bus.rf_we && (bus.rf_reg != '0);
  assign capture  = in_run && !start && (rf_hit || bus.mem_we);
  assign pop_fire = bus.rd_ready && !fifo_empty;
  assign lost     = capture && fifo_full && !pop_fire;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cause_q <= HALT_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    if (start) begin
      state_d = S_RUN;
      cause_d = HALT_NONE;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_RUN: begin
          if (limit_at) begin
            state_d = S_DONE;
            cause_d = HALT_LIMIT;
          end else if (stall_at) begin
            state_d = S_DONE;
            cause_d = HALT_STALL;
          end
        end
        S_DONE: state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cyc_q      <= '0;
      stall_q    <= '0;
      prev_pc_q  <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      prev_pc_q <= bus.pc;
      if (start) begin
        cyc_q      <= '0;
        stall_q    <= '0;
        overflow_q <= 1'b0;
        drop_q     <= '0;
      end else begin
        if (in_run && !limit_at) cyc_q <= cyc_q + 1'b1;
        if (in_run) stall_q <= pc_same ? stall_q + 1'b1 : '0;
        if (lost) begin
          overflow_q <= 1'b1;
          if (drop_q != '1) drop_q <= drop_q + 1'b1;
        end
      end
    end
  end

  // Inactive channel fields stay zero so a consumer can ignore them blindly.
  always_comb begin
    push_entry       = '0;
    push_entry.cycle = cyc_q;
    if (rf_hit) begin
      push_entry.rf_valid = 1'b1;
      push_entry.rf_reg   = bus.rf_reg;
      push_entry.rf_data  = bus.rf_data;
    end
    if (bus.mem_we) begin
      push_entry.mem_valid = 1'b1;
      push_entry.mem_addr  = bus.mem_addr;
      push_entry.mem_data  = bus.mem_data;
    end
  end

  trace_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .clear    (start),
    .push     (capture),
    .pop      (bus.rd_ready),
    .overwrite(overwrite),
    .wdata    (push_entry),
    .rdata    (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign head             = fifo_rdata;
  assign bus.rd_valid     = !fifo_empty;
  assign bus.rd_cycle     = head.cycle;
  assign bus.rd_rf_valid  = head.rf_valid;
  assign bus.rd_rf_reg    = head.rf_reg;
  assign bus.rd_rf_data   = head.rf_data;
  assign bus.rd_mem_valid = head.mem_valid;
  assign bus.rd_mem_addr  = head.mem_addr;
  assign bus.rd_mem_data  = head.mem_data;

  assign running    = in_run;
  assign done       = (state_q == S_DONE);
  assign halt_cause = cause_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_proc_trace_buffer.sv
// Scoreboard bench for proc_trace_buffer: a queue-based reference model predicts every
// drained entry and the status outputs; a negedge monitor compares the DUT against it.
module tb_proc_trace_buffer;
  import proc_trace_pkg::*;

  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 12;
  localparam int REG_W       = 5;
  localparam int DEPTH       = 16;
  localparam int CYC_W       = 16;
  localparam int CYCLE_LIMIT = 50;
  localparam int HALT_REPEAT = 4;

  typedef struct {
    bit          start;
    logic [31:0] pc;
    bit          rf_we;
    logic [4:0]  rf_reg;
    logic [31:0] rf_data;
    bit          mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_data;
    bit          ready;
  } stim_t;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             running;
  logic             done;
  logic [1:0]       halt_cause;
  logic             overflow;
  logic [CYC_W-1:0] drop_count;

  proc_trace_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W), .CYC_W(CYC_W)) bus ();

  proc_trace_buffer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W), .DEPTH(DEPTH),
    .CYC_W(CYC_W), .CYCLE_LIMIT(CYCLE_LIMIT), .HALT_REPEAT(HALT_REPEAT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .running   (running),
    .done      (done),
    .halt_cause(halt_cause),
    .overflow  (overflow),
    .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  // Reference model: contents of the log plus run bookkeeping, in plain terms.
  trace_entry_t model_q[$];
  trace_entry_t exp_q[$];
  bit           m_running, m_done, m_overflow;
  int           m_stamp, m_runlen, m_cause, m_drops;
  logic [31:0]  m_last_pc;

  bit           e_valid, e_running, e_done, e_overflow;
  int           e_cause, e_drops;

  int           vectors = 0;
  int           miscompares = 0;
  int           pop_count = 0;
  int           last_pop_cycle = -1;
  logic [31:0]  cur_pc = 32'h100;
  trace_entry_t mon_e;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    model_q.delete();
    exp_q.delete();
    m_running = 0; m_done = 0; m_overflow = 0;
    m_stamp = 0; m_runlen = 0; m_cause = 0; m_drops = 0;
    e_valid = 0; e_running = 0; e_done = 0; e_overflow = 0;
    e_cause = 0; e_drops = 0;
  endtask

  // Drives one cycle of inputs and advances the model by the edge that ends it.
  task automatic applyStimulus(input stim_t s);
    bit           full_before;
    bit           pop;
    bit           rf_v;
    trace_entry_t e;
    e_valid    = (model_q.size() != 0);
    e_running  = m_running;
    e_done     = m_done;
    e_cause    = m_cause;
    e_overflow = m_overflow;
    e_drops    = m_drops;

    start        = s.start;
    bus.pc       = s.pc;
    bus.rf_we    = s.rf_we;
    bus.rf_reg   = s.rf_reg;
    bus.rf_data  = s.rf_data;
    bus.mem_we   = s.mem_we;
    bus.mem_addr = s.mem_addr;
    bus.mem_data = s.mem_data;
    bus.rd_ready = s.ready && !s.start;

    if (s.start) begin
      model_q.delete();
      m_running = 1; m_done = 0; m_stamp = 0; m_cause = 0;
      m_overflow = 0; m_drops = 0; m_runlen = 1;
    end else begin
      full_before = (model_q.size() == DEPTH);
      pop = s.ready && (model_q.size() != 0);
      if (pop) exp_q.push_back(model_q.pop_front());
      if (m_running) begin
        m_runlen = (s.pc == m_last_pc) ? m_runlen + 1 : 1;
        rf_v = s.rf_we && (s.rf_reg != 0);
        if (rf_v || s.mem_we) begin
          e = '0;
          e.cycle = 16'(m_stamp);
          if (rf_v) begin
            e.rf_valid = 1; e.rf_reg = s.rf_reg; e.rf_data = s.rf_data;
          end
          if (s.mem_we) begin
            e.mem_valid = 1; e.mem_addr = s.mem_addr; e.mem_data = s.mem_data;
          end
          if (full_before && !pop) begin
            m_overflow = 1;
            if (m_drops < 65535) m_drops++;
`ifdef PROC_TRACE_WRAP_EN
            model_q.delete(0);
            model_q.push_back(e);
`endif
          end else begin
            model_q.push_back(e);
          end
        end
        if (m_stamp == CYCLE_LIMIT - 1) begin
          m_running = 0; m_done = 1; m_cause = 1;
        end else if (m_runlen >= HALT_REPEAT) begin
          m_running = 0; m_done = 1; m_cause = 2;
        end else begin
          m_stamp++;
        end
      end
    end
    m_last_pc = s.pc;
    @(posedge clock);
    #1;
  endtask

  task automatic runCycle(input bit hold, input bit rf_we, input logic [4:0] rf_reg,
                          input logic [31:0] rf_data, input bit mem_we,
                          input logic [11:0] mem_addr, input logic [31:0] mem_data,
                          input bit ready);
    stim_t s;
    if (!hold) cur_pc += 4;
    s.start = 0; s.pc = cur_pc; s.rf_we = rf_we; s.rf_reg = rf_reg; s.rf_data = rf_data;
    s.mem_we = mem_we; s.mem_addr = mem_addr; s.mem_data = mem_data; s.ready = ready;
    applyStimulus(s);
  endtask

  task automatic startRun();
    stim_t s;
    cur_pc += 4;
    s = '{start: 1, pc: cur_pc, rf_we: 0, rf_reg: 0, rf_data: 0,
          mem_we: 0, mem_addr: 0, mem_data: 0, ready: 0};
    applyStimulus(s);
  endtask

  task automatic quiet(input int n, input bit ready);
    for (int i = 0; i < n; i++) runCycle(0, 0, 0, 0, 0, 0, 0, ready);
  endtask

  // Monitor: status every cycle, entry contents on every DUT pop.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        checkOutput("rd_valid", bus.rd_valid, e_valid);
        checkOutput("running", running, e_running);
        checkOutput("done", done, e_done);
        checkOutput("halt_cause", halt_cause, e_cause);
        checkOutput("overflow", overflow, e_overflow);
        checkOutput("drop_count", drop_count, e_drops);
        if (bus.rd_valid && bus.rd_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL pop_unexpected: got entry stamp %0d, expected no entry",
                     bus.rd_cycle);
          end else begin
            mon_e = exp_q.pop_front();
            checkOutput("rd_cycle", bus.rd_cycle, mon_e.cycle);
            checkOutput("rd_rf_valid", bus.rd_rf_valid, mon_e.rf_valid);
            checkOutput("rd_rf_reg", bus.rd_rf_reg, mon_e.rf_reg);
            checkOutput("rd_rf_data", bus.rd_rf_data, mon_e.rf_data);
            checkOutput("rd_mem_valid", bus.rd_mem_valid, mon_e.mem_valid);
            checkOutput("rd_mem_addr", bus.rd_mem_addr, mon_e.mem_addr);
            checkOutput("rd_mem_data", bus.rd_mem_data, mon_e.mem_data);
            pop_count++;
            last_pop_cycle = int'(bus.rd_cycle);
          end
        end
      end
    end
  end

  initial begin
    int   p0;
    int   thresh;
    bit   hold;
    stim_t s;
    modelReset();
    bus.pc = 0; bus.rf_we = 0; bus.rf_reg = 0; bus.rf_data = 0;
    bus.mem_we = 0; bus.mem_addr = 0; bus.mem_data = 0; bus.rd_ready = 0;
    m_last_pc = 0;

    #12;
    checkOutput("reset_rd_valid", bus.rd_valid, 0);
    checkOutput("reset_running", running, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_halt_cause", halt_cause, 0);
    checkOutput("reset_overflow", overflow, 0);
    checkOutput("reset_drop_count", drop_count, 0);
    checkOutput("reset_rd_cycle", bus.rd_cycle, 0);
    @(posedge clock); #1;
    reset = 1;
    @(posedge clock); #1;

    $display("[TB] reset mid-run with five logged entries");
    startRun();
    for (int i = 0; i < 5; i++) runCycle(0, 1, 5'(i + 1), 32'(i), 0, 0, 0, 0);
    quiet(1, 0);
    checkOutput("pre_reset_rd_valid", bus.rd_valid, 1);
    reset = 0;
    #1;
    checkOutput("async_rd_valid", bus.rd_valid, 0);
    checkOutput("async_running", running, 0);
    checkOutput("async_drop_count", drop_count, 0);
    checkOutput("async_rd_cycle", bus.rd_cycle, 0);
    modelReset();
    @(posedge clock); #1;
    reset = 1;
    @(posedge clock); #1;

    $display("[TB] directed entries and r0 filtering");
    p0 = pop_count;
    startRun();
    for (int i = 0; i < CYCLE_LIMIT + 5; i++) begin
      if (i == 2)      runCycle(0, 1, 5'd3, 32'd7, 0, 0, 0, 0);
      else if (i == 4) runCycle(0, 0, 0, 0, 1, 12'd10, 32'd9, 0);
      else if (i == 6) runCycle(0, 1, 5'd0, 32'd5, 1, 12'd1, 32'd6, 0);
      else if (i == 7) runCycle(0, 1, 5'd0, 32'd8, 0, 0, 0, 0);
      else             runCycle(0, 0, 0, 0, 0, 0, 0, i >= 10);
    end
    checkOutput("dir_entries", pop_count - p0, 3);
    checkOutput("dir_done", done, 1);

    $display("[TB] cycle limit with an event every cycle");
    p0 = pop_count;
    startRun();
    for (int i = 0; i < CYCLE_LIMIT + 5; i++)
      runCycle(0, 1, 5'($urandom_range(31, 1)), $urandom, 0, 0, 0, 1);
    checkOutput("limit_entries", pop_count - p0, CYCLE_LIMIT);
    checkOutput("limit_last_stamp", last_pop_cycle, CYCLE_LIMIT - 1);
    checkOutput("limit_cause", halt_cause, HALT_LIMIT);

    $display("[TB] stalled pc ends the run");
    startRun();
    cur_pc = 32'h1000;
    for (int i = 0; i < 20; i++) begin
      hold = (i > 10);
      if (i == 10) cur_pc = 32'd36;
      runCycle(hold, 0, 0, 0, 1, 12'(i), 32'(i * 3), 1);
    end
    checkOutput("stall_cause", halt_cause, HALT_STALL);
    checkOutput("stall_last_stamp", last_pop_cycle, 13);
    cur_pc = 32'h2000;

    $display("[TB] overflow with no reads");
    startRun();
    for (int i = 0; i < 20; i++) runCycle(0, 1, 5'(1 + i % 31), 32'(100 + i), 0, 0, 0, 0);
    quiet(5, 0);
    checkOutput("ovf_flag", overflow, 1);
    checkOutput("ovf_drop_count", drop_count, 4);
`ifdef PROC_TRACE_WRAP_EN
    checkOutput("ovf_head_stamp", bus.rd_cycle, 4);
`else
    checkOutput("ovf_head_stamp", bus.rd_cycle, 0);
`endif
    quiet(30, 1);

    $display("[TB] randomized traffic");
    thresh = 2;
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) thresh = $urandom_range(4, 0);
      if ((!m_running && ($urandom % 6 == 0)) || ($urandom % 100 == 0)) begin
        startRun();
      end else begin
        s.start    = 0;
        if ($urandom % 4 != 0) cur_pc += 4;
        s.pc       = cur_pc;
        s.rf_we    = $urandom % 2;
        s.rf_reg   = 5'($urandom % 4);
        s.rf_data  = $urandom;
        s.mem_we   = ($urandom % 3 == 0);
        s.mem_addr = 12'($urandom);
        s.mem_data = $urandom;
        s.ready    = ($urandom % 4 < thresh);
        applyStimulus(s);
      end
    end
    quiet(DEPTH + 4, 1);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    checkOutput("model_drained", model_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
